fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
Downstream consumer of the team FIFO. It drains FIFO_WIDTH-bit words through the FIFO read port and packs each pair into one 2*FIFO_WIDTH-bit beat. Beats leave on a valid/ready stream. A flush command forces out a trailing odd word as a half-valid beat. The block sits between the FIFO read side and the wide downstream datapath.

Parameters:
FIFO_WIDTH, 16, width of one FIFO word; output beat is 2*FIFO_WIDTH
CNT_WIDTH, 16, width of the word counter

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
fifo_empty  in  1  FIFO empty flag
fifo_data_out  in  FIFO_WIDTH  FIFO read data, valid one cycle after an accepted read
fifo_underflow  in  1  FIFO underflow flag
fifo_rd_en  out  1  read request to FIFO
m_valid  out  1  output beat valid
m_data  out  2*FIFO_WIDTH  packed beat: first word in [W-1:0], second in [2W-1:W]
m_half  out  1  beat carries only the low word; high half is zero
m_ready  in  1  downstream accept
flush  in  1  single-cycle request to emit any partial word
flush_done  out  1  one-cycle pulse when flush is complete
word_cnt  out  CNT_WIDTH  FIFO words captured since reset, wraps
err_underflow  out  1  sticky, set when fifo_underflow is seen high

Behaviour:
- Reset (async assert, sync release):
  - fifo_rd_en, m_valid, m_half, flush_done, err_underflow all 0.
  - m_data 0, word_cnt 0.
  - Output queue, assembler and in-flight flag are cleared; any in-flight data is dropped.
  - state = RUN.
- Read latency: a read is accepted when fifo_rd_en=1 and fifo_empty=0 at edge N. fifo_data_out is sampled at edge N+1. pend flag = read in flight.
- Internal storage:
  - assembler: lo_reg plus lo_valid.
  - 2-entry output queue of packed beats {data, half}. m_valid/m_data/m_half come from the queue head, registered.
- Credit in half-slots: credit = 4 - 2*q_cnt - lo_valid - pend, plus 2 if (m_valid && m_ready) this cycle.
- fifo_rd_en = (state==RUN) && !fifo_empty && credit>=1.
  - This is the only combinational path from m_ready; no other output is combinational.
  - Never read when empty; credit can never go negative.
- Capture of a returned word:
  - lo_valid=0: store it in lo_reg and set lo_valid.
  - lo_valid=1: push {word, lo_reg} with half=0 and clear lo_valid.
  - word_cnt increments once per captured word, wrapping modulo 2^CNT_WIDTH.
- Output: a beat is popped on m_valid && m_ready. Push and pop in the same cycle leave q_cnt unchanged. Full throughput is one word per cycle with m_ready held high.
- State machine:
  - RUN: normal. flush=1 moves to DRAIN; no new reads are issued from that edge.
  - DRAIN: wait until pend=0 and the landed word has been captured, then go to EMIT.
  - EMIT:
    - lo_valid=1: wait for a free queue entry (q_cnt<2 or a pop this cycle), push {0, lo_reg} with half=1, clear lo_valid, go to DONE.
    - lo_valid=0: go directly to DONE.
  - DONE: flush_done=1 for one cycle, then RUN.
  - flush is ignored outside RUN.
  - Beats already queued still drain normally during a flush.
- Ordering: beats leave strictly in FIFO order. A half beat is never followed by a beat holding older data.
- err_underflow: set on any cycle with fifo_underflow=1; cleared only by rst.
- m_data/m_half hold their value while m_valid=1 and m_ready=0.

Decomposition:
- Package fifo_rd_pkg:
  - typedef beat_t struct {logic half; logic [2*FIFO_WIDTH-1:0] data}.
  - state enum {RUN, DRAIN, EMIT, DONE}.
  - localparam CREDIT_MAX=4.
- Sub-module fifo_rd_outq: 2-entry beat queue with push/pop/q_cnt, registered head outputs.

Test Plan:
1. 4 words 0x1111,0x2222,0x3333,0x4444; m_ready=1 -> beats 0x2222_1111 then 0x4444_3333, m_half=0; word_cnt=4; no gap in fifo_rd_en while not empty.
2. m_ready=0 with 8 words in FIFO -> exactly 4 reads accepted, then fifo_rd_en=0. m_data stays at 0x2222_1111 while stalled. Raising m_ready releases both beats, then reading resumes.
3. 3 words 0xA001,0xA002,0xA003, then flush -> beat 0xA002_A001 (half=0), beat 0x0000_A003 (half=1), one flush_done pulse, then state RUN.
4. Flush with assembler empty and FIFO empty -> no beat, flush_done pulses exactly once within 3 cycles.
5. rst asserted mid-stream while pend=1 and lo_valid=1 -> all outputs 0 asynchronously. After release, new words 0x5555,0x6666 give beat 0x6666_5555 with no stale data.
6. fifo_underflow pulsed once -> err_underflow=1 and stays 1 through further traffic until rst.

Source files
------------

// File: rtl/fifo_rd_packer_pkg.sv
// rtl/fifo_rd_packer_pkg.sv - shared types and constants for the FIFO read packer
package fifo_rd_pkg;

    localparam int PKG_FIFO_WIDTH = 16;
    localparam int CREDIT_MAX     = 4;

    typedef struct packed {
        logic                          half;
        logic [2*PKG_FIFO_WIDTH-1:0]   data;
    } beat_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_rd_packer_outq.sv
// rtl/fifo_rd_packer_outq.sv - two-entry beat queue with registered head outputs
module fifo_rd_outq #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          push_half,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    q_cnt,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_half
);

    logic          head_valid_q, head_valid_d;
    logic          head_half_q, head_half_d;
    logic [DW-1:0] head_data_q, head_data_d;
    logic          tail_valid_q, tail_valid_d;
    logic          tail_half_q, tail_half_d;
    logic [DW-1:0] tail_data_q, tail_data_d;

    always_comb begin
        head_valid_d = head_valid_q;
        head_half_d  = head_half_q;
        head_data_d  = head_data_q;
        tail_valid_d = tail_valid_q;
        tail_half_d  = tail_half_q;
        tail_data_d  = tail_data_q;
        if (pop) begin
            if (tail_valid_q) begin
                head_half_d  = tail_half_q;
                head_data_d  = tail_data_q;
                tail_valid_d = push;
                if (push) begin
                    tail_half_d = push_half;
                    tail_data_d = push_data;
                end
            end else begin
                // Head data is left in place when the queue empties; m_valid gates it.
                head_valid_d = push;
                if (push) begin
                    head_half_d = push_half;
                    head_data_d = push_data;
                end
            end
        end else if (push) begin
            if (!head_valid_q) begin
                head_valid_d = 1'b1;
                head_half_d  = push_half;
                head_data_d  = push_data;
            end else begin
                tail_valid_d = 1'b1;
                tail_half_d  = push_half;
                tail_data_d  = push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_valid_q <= 1'b0;
            head_half_q  <= 1'b0;
            head_data_q  <= '0;
            tail_valid_q <= 1'b0;
            tail_half_q  <= 1'b0;
            tail_data_q  <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_half_q  <= head_half_d;
            head_data_q  <= head_data_d;
            tail_valid_q <= tail_valid_d;
            tail_half_q  <= tail_half_d;
            tail_data_q  <= tail_data_d;
        end
    end

    assign q_cnt   = {1'b0, head_valid_q} + {1'b0, tail_valid_q};
    assign m_valid = head_valid_q;
    assign m_data  = head_data_q;
    assign m_half  = head_half_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - drains FIFO words and packs pairs into double-width beats
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_empty,
    input  logic [FIFO_WIDTH-1:0]   fifo_data_out,
    input  logic                    fifo_underflow,
    output logic                    fifo_rd_en,
    output logic                    m_valid,
    output logic [2*FIFO_WIDTH-1:0] m_data,
    output logic                    m_half,
    input  logic                    m_ready,
    input  logic                    flush,
    output logic                    flush_done,
    output logic [CNT_WIDTH-1:0]    word_cnt,
    output logic                    err_underflow
);

    localparam int BW = 2 * FIFO_WIDTH;

    state_t                  state_q, state_d;
    logic [FIFO_WIDTH-1:0]   lo_q, lo_d;
    logic                    lo_valid_q, lo_valid_d;
    logic                    pend_q, pend_d;
    logic [CNT_WIDTH-1:0]    word_cnt_q, word_cnt_d;
    logic                    err_q, err_d;
    logic                    flush_done_q, flush_done_d;

    logic                    push, push_half;
    logic [BW-1:0]           push_data;
    logic                    pop;
    logic [1:0]              q_cnt;
    logic [2:0]              used, space;

    fifo_rd_outq #(.DW(BW)) u_outq (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_half (push_half),
        .push_data (push_data),
        .pop       (pop),
        .q_cnt     (q_cnt),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_half    (m_half)
    );

    assign pop = m_valid && m_ready;

    // Half-slot accounting: a queued beat costs two, a held or in-flight word costs one.
    assign used  = {q_cnt, 1'b0} + {2'b00, lo_valid_q} + {2'b00, pend_q};
    assign space = pop ? 3'(CREDIT_MAX + 2) : 3'(CREDIT_MAX);

    assign fifo_rd_en = !rst && (state_q == RUN) && !fifo_empty && (space > used);

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        lo_valid_d   = lo_valid_q;
        pend_d       = fifo_rd_en;
        word_cnt_d   = word_cnt_q;
        err_d        = err_q | fifo_underflow;
        push         = 1'b0;
        push_half    = 1'b0;
        push_data    = '0;

        if (pend_q) begin
            word_cnt_d = word_cnt_q + 1'b1;
            if (lo_valid_q) begin
                push       = 1'b1;
                push_data  = {fifo_data_out, lo_q};
                lo_valid_d = 1'b0;
            end else begin
                lo_d       = fifo_data_out;
                lo_valid_d = 1'b1;
            end
        end

        case (state_q)
            RUN:   if (flush) state_d = DRAIN;
            DRAIN: if (!pend_q) state_d = EMIT;
            EMIT: begin
                // No reads are issued outside RUN, so pend_q is clear and this push cannot collide.
                if (lo_valid_q) begin
                    if ((q_cnt != 2'd2) || pop) begin
                        push       = 1'b1;
                        push_half  = 1'b1;
                        push_data  = {{FIFO_WIDTH{1'b0}}, lo_q};
                        lo_valid_d = 1'b0;
                        state_d    = DONE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase

        flush_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            lo_q         <= '0;
            lo_valid_q   <= 1'b0;
            pend_q       <= 1'b0;
            word_cnt_q   <= '0;
            err_q        <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            lo_valid_q   <= lo_valid_d;
            pend_q       <= pend_d;
            word_cnt_q   <= word_cnt_d;
            err_q        <= err_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign word_cnt      = word_cnt_q;
    assign err_underflow = err_q;
    assign flush_done    = flush_done_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;
    import fifo_rd_pkg::*;

    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fifo_empty;
    logic [W-1:0]     fifo_data_out = '0;
    logic             fifo_underflow;
    logic             fifo_rd_en;
    logic             m_valid;
    logic [2*W-1:0]   m_data;
    logic             m_half;
    logic             m_ready;
    logic             flush;
    logic             flush_done;
    logic [15:0]      word_cnt;
    logic             err_underflow;

    logic [W-1:0]     fmem [0:1023];
    int               wr_idx = 0;
    int               rd_idx = 0;
    logic [W-1:0]     mw [$];
    beat_t            exp_q [$];
    logic [15:0]      wc_model = '0;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;
    int beat_count = 0;

    fifo_rd_packer #(.FIFO_WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_half         (m_half),
        .m_ready        (m_ready),
        .flush          (flush),
        .flush_done     (flush_done),
        .word_cnt       (word_cnt),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data_out <= fmem[rd_idx];
            rd_idx        <= rd_idx + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [W-1:0] w, input bit modeled);
        fmem[wr_idx] = w;
        wr_idx++;
        if (modeled) begin
            wc_model++;
            mw.push_back(w);
            if (mw.size() == 2) begin
                exp_q.push_back(beat_t'({1'b0, mw[1], mw[0]}));
                mw.delete();
            end
        end
    endtask

    task automatic model_flush();
        if (mw.size() == 1) begin
            exp_q.push_back(beat_t'({1'b1, {W{1'b0}}, mw[0]}));
            mw.delete();
        end
    endtask

    always begin
        @(negedge clk);
        #3;
        if (flush_done) fd_count++;
        if (!rst && m_valid && m_ready) begin
            beat_count++;
            if (exp_q.size() == 0) begin
                check("beat_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("beat", {m_half, m_data}, 64'(b));
            end
        end
    end

    initial begin
        int base;
        int fdb;
        int bcb;
        int n;
        fifo_underflow = 1'b0;
        m_ready = 1'b0;
        flush = 1'b0;

        #2 rst = 1'b1;
        #1;
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_half", m_half, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_err", err_underflow, 0);
        cycles(2);
        rst = 1'b0;

        // Four words streamed with downstream always ready
        m_ready = 1'b1;
        base = rd_idx;
        push_word(16'h1111, 1); push_word(16'h2222, 1);
        push_word(16'h3333, 1); push_word(16'h4444, 1);
        cycles(4);
        check("t1_back_to_back_reads", rd_idx - base, 4);
        cycles(6);
        check("t1_word_cnt", word_cnt, 4);
        check("t1_all_beats", exp_q.size(), 0);

        // Backpressure: credit limits reads to two beats' worth
        m_ready = 1'b0;
        base = rd_idx;
        for (int k = 1; k <= 8; k++) push_word(16'(16'h1111 * k), 1);
        cycles(10);
        check("t2_reads_stalled", rd_idx - base, 4);
        check("t2_rd_en_low", fifo_rd_en, 0);
        check("t2_m_valid", m_valid, 1);
        check("t2_m_data", m_data, 32'h2222_1111);
        cycles(3);
        check("t2_m_data_hold", m_data, 32'h2222_1111);
        m_ready = 1'b1;
        cycles(14);
        check("t2_reads_resumed", rd_idx - base, 8);
        check("t2_all_beats", exp_q.size(), 0);
        check("t2_word_cnt", word_cnt, 12);

        // Odd word count closed out by flush
        push_word(16'hA001, 1); push_word(16'hA002, 1); push_word(16'hA003, 1);
        cycles(6);
        fdb = fd_count;
        flush = 1'b1;
        model_flush();
        cycles(1);
        flush = 1'b0;
        cycles(6);
        check("t3_flush_done_once", fd_count - fdb, 1);
        check("t3_all_beats", exp_q.size(), 0);
        check("t3_state_run", dut.state_q == RUN, 1);
        check("t3_word_cnt", word_cnt, 15);

        // Flush with nothing held
        fdb = fd_count;
        bcb = beat_count;
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        cycles(2);
        #4;
        check("t4_flush_done_in_3", fd_count - fdb, 1);
        cycles(4);
        check("t4_flush_done_exactly_once", fd_count - fdb, 1);
        check("t4_no_beat", beat_count - bcb, 0);

        // Underflow is sticky through random traffic and a further flush
        fifo_underflow = 1'b1;
        cycles(1);
        fifo_underflow = 1'b0;
        #1;
        check("t6_err_set", err_underflow, 1);
        n = 0;
        for (int i = 0; i < 200 && n < 41; i++) begin
            @(negedge clk);
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                push_word(16'($urandom), 1);
                n++;
            end
        end
        m_ready = 1'b1;
        cycles(60);
        check("t6_fifo_drained", fifo_empty, 1);
        fdb = fd_count;
        flush = 1'b1;
        model_flush();
        cycles(1);
        flush = 1'b0;
        cycles(8);
        check("t6_rand_all_beats", exp_q.size(), 0);
        check("t6_rand_word_cnt", word_cnt, wc_model);
        check("t6_rand_flush_done", fd_count - fdb, 1);
        check("t6_err_sticky", err_underflow, 1);

        // Reset in the middle of a pair with a read in flight
        push_word(16'h7777, 0); push_word(16'h8888, 0); push_word(16'h9999, 0);
        cycles(2);
        check("t5_pend_before_rst", dut.pend_q, 1);
        check("t5_lo_before_rst", dut.lo_valid_q, 1);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_rd_en", fifo_rd_en, 0);
        check("t5_rst_m_valid", m_valid, 0);
        check("t5_rst_m_data", m_data, 0);
        check("t5_rst_m_half", m_half, 0);
        check("t5_rst_word_cnt", word_cnt, 0);
        check("t5_rst_err", err_underflow, 0);
        wr_idx = rd_idx;
        mw.delete();
        exp_q.delete();
        wc_model = '0;
        cycles(2);
        rst = 1'b0;
        bcb = beat_count;
        push_word(16'h5555, 1); push_word(16'h6666, 1);
        cycles(8);
        check("t5_one_beat", beat_count - bcb, 1);
        check("t5_all_beats", exp_q.size(), 0);
        check("t5_word_cnt", word_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
